// File: rtl/inv_linear_transform_pipe.sv
// Inverse Serpent linear transform (LT^-1) on four 32-bit bitslice words,
// split over STAGES elastic register stages with a valid/ready handshake.
module inv_linear_transform_pipe #(
    parameter int STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_word_0,
    input  logic [31:0] i_word_1,
    input  logic [31:0] i_word_2,
    input  logic [31:0] i_word_3,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_word_0,
    output logic [31:0] o_word_1,
    output logic [31:0] o_word_2,
    output logic [31:0] o_word_3,
    output logic        o_busy
);

    typedef logic [3:0][31:0] blk_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic blk_t half_a(input blk_t x);
        blk_t y;
        y    = x;
        y[2] = ror32(y[2], 22);
        y[0] = ror32(y[0], 5);
        y[2] = y[2] ^ y[3] ^ (y[1] << 7);
        y[0] = y[0] ^ y[1] ^ y[3];
        y[3] = ror32(y[3], 7);
        y[1] = ror32(y[1], 1);
        return y;
    endfunction

    function automatic blk_t half_b(input blk_t x);
        blk_t y;
        y    = x;
        y[3] = y[3] ^ y[2] ^ (y[0] << 3);
        y[1] = y[1] ^ y[0] ^ y[2];
        y[2] = ror32(y[2], 3);
        y[0] = ror32(y[0], 13);
        return y;
    endfunction

    generate
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("inv_linear_transform_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    blk_t              in_blk;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_adv;
    blk_t              stage_data [STAGES];
    logic              adv_last;

    assign in_blk   = {i_word_3, i_word_2, i_word_1, i_word_0};
    // Last stage may load when empty or when its contents leave this cycle.
    assign adv_last = !stage_valid[STAGES-1] || i_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic valid_q;
        blk_t data_q;
        blk_t data_d;
        logic up_valid;
        blk_t up_data;

        if (gi == 0) begin : g_first
            assign up_valid = i_valid;
            assign up_data  = in_blk;
        end else begin : g_next
            assign up_valid = stage_valid[gi-1];
            assign up_data  = stage_data[gi-1];
        end

        // With at most two stages, any non-last stage feeds the last one directly.
        if (gi == STAGES - 1) begin : g_adv_last
            assign stage_adv[gi] = adv_last;
        end else begin : g_adv_mid
            assign stage_adv[gi] = !valid_q || adv_last;
        end

        if (STAGES == 1) begin : g_full
            assign data_d = half_b(half_a(up_data));
        end else if (gi == 0) begin : g_half_a
            assign data_d = half_a(up_data);
        end else begin : g_half_b
            assign data_d = half_b(up_data);
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (stage_adv[gi]) begin
                valid_q <= up_valid;
                if (up_valid) begin
                    data_q <= data_d;
                end
            end
        end

        assign stage_valid[gi] = valid_q;
        assign stage_data[gi]  = data_q;
    end

    assign o_ready  = stage_adv[0];
    assign o_valid  = stage_valid[STAGES-1];
    assign o_busy   = |stage_valid;
    assign o_word_0 = stage_data[STAGES-1][0];
    assign o_word_1 = stage_data[STAGES-1][1];
    assign o_word_2 = stage_data[STAGES-1][2];
    assign o_word_3 = stage_data[STAGES-1][3];

endmodule

// File: tb/tb_inv_linear_transform_pipe.sv
// Bench for inv_linear_transform_pipe: instance 0 has STAGES=1, instance 1 has STAGES=2.
// Outputs are checked by pushing them through the forward Serpent LT and comparing to the inputs.
module tb_inv_linear_transform_pipe;

    logic        clk;
    logic        rst;
    logic        v_in   [2];
    logic        ordy   [2];
    logic        ov     [2];
    logic        rdy_dn [2];
    logic        busy   [2];
    logic [31:0] w_in   [2][4];
    logic [31:0] w_out  [2][4];
    logic        acc    [2];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Standard Serpent forward linear transform.
    function automatic logic [127:0] fwd_lt(input logic [127:0] b);
        logic [31:0] x0, x1, x2, x3;
        {x3, x2, x1, x0} = b;
        x0 = rol32(x0, 13);
        x2 = rol32(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rol32(x1, 1);
        x3 = rol32(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rol32(x0, 5);
        x2 = rol32(x2, 22);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] out_blk(input int k);
        return {w_out[k][3], w_out[k][2], w_out[k][1], w_out[k][0]};
    endfunction

    task automatic set_words(input int k, input logic [127:0] b);
        for (int j = 0; j < 4; j++) w_in[k][j] = b[32*j +: 32];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [127:0] exp_q [$];
        logic [127:0] ob;
        logic [127:0] ib;
        logic [127:0] held;
        logic         hold;
        int           n_in;
        int           n_out;

        inv_linear_transform_pipe #(.STAGES(gi + 1)) u_dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_valid  (v_in[gi]),
            .o_ready  (ordy[gi]),
            .i_word_0 (w_in[gi][0]),
            .i_word_1 (w_in[gi][1]),
            .i_word_2 (w_in[gi][2]),
            .i_word_3 (w_in[gi][3]),
            .o_valid  (ov[gi]),
            .i_ready  (rdy_dn[gi]),
            .o_word_0 (w_out[gi][0]),
            .o_word_1 (w_out[gi][1]),
            .o_word_2 (w_out[gi][2]),
            .o_word_3 (w_out[gi][3]),
            .o_busy   (busy[gi])
        );

        assign ob = {w_out[gi][3], w_out[gi][2], w_out[gi][1], w_out[gi][0]};
        assign ib = {w_in[gi][3], w_in[gi][2], w_in[gi][1], w_in[gi][0]};

        // Transfers seen here take effect at the following rising edge.
        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                n_in  <= 0;
                n_out <= 0;
                hold  <= 1'b0;
                held  <= '0;
            end else begin
                check_eq("busy", 128'(busy[gi]), 128'(n_in != n_out));
                if (hold) begin
                    check_eq("hold_valid", 128'(ov[gi]), 128'(1));
                    check_eq("hold_words", ob, held);
                end
                if (ov[gi] && rdy_dn[gi]) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_out", 128'(1), 128'(0));
                    end else begin
                        check_eq("round_trip", fwd_lt(ob), exp_q.pop_front());
                    end
                    $display("inst%0d out #%0d words %h", gi, n_out, ob);
                    n_out <= n_out + 1;
                end
                if (v_in[gi] && ordy[gi]) begin
                    exp_q.push_back(ib);
                    n_in <= n_in + 1;
                end
                hold <= ov[gi] && !rdy_dn[gi];
                held <= ob;
            end
        end
    end

    logic [127:0] vec_a, vec_b, vec_c;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            v_in[k]   = 1'b0;
            rdy_dn[k] = 1'b1;
            acc[k]    = 1'b0;
            set_words(k, '0);
        end
        repeat (3) tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_valid", 128'(ov[k]), 128'(0));
            check_eq("rst_busy", 128'(busy[k]), 128'(0));
            check_eq("rst_ready", 128'(ordy[k]), 128'(1));
            check_eq("rst_words", out_blk(k), 128'(0));
        end
        tick();

        // Known vector and all-zero vector through the two-stage instance.
        for (int t = 0; t < 2; t++) begin
            vec_a = (t == 0) ? {32'h00800000, 32'h00002800, 32'h00004000, 32'h100C0000} : '0;
            vec_b = (t == 0) ? 128'h1 : '0;
            set_words(1, vec_a);
            v_in[1] = 1'b1;
            tick();
            v_in[1] = 1'b0;
            check_eq("kv_lat1", 128'(ov[1]), 128'(0));
            tick();
            check_eq("kv_valid", 128'(ov[1]), 128'(1));
            check_eq("kv_words", out_blk(1), vec_b);
            tick();
            check_eq("kv_pulse", 128'(ov[1]), 128'(0));
        end

        // Backpressure: three vectors offered while downstream is stalled.
        vec_a = rand_blk();
        vec_b = rand_blk();
        vec_c = rand_blk();
        rdy_dn[1] = 1'b0;
        set_words(1, vec_a);
        v_in[1] = 1'b1;
        #1 check_eq("bp_ready0", 128'(ordy[1]), 128'(1));
        tick();
        set_words(1, vec_b);
        #1 check_eq("bp_ready1", 128'(ordy[1]), 128'(1));
        tick();
        set_words(1, vec_c);
        #1 check_eq("bp_ready2", 128'(ordy[1]), 128'(0));
        repeat (2) begin
            tick();
            check_eq("bp_full", 128'(ordy[1]), 128'(0));
            check_eq("bp_head", fwd_lt(out_blk(1)), vec_a);
        end
        rdy_dn[1] = 1'b1;
        #1 check_eq("bp_release", 128'(ordy[1]), 128'(1));
        tick();
        v_in[1] = 1'b0;
        check_eq("bp_second", fwd_lt(out_blk(1)), vec_b);
        tick();
        check_eq("bp_third", fwd_lt(out_blk(1)), vec_c);
        tick();
        check_eq("bp_drained", 128'(ov[1]), 128'(0));

        // Streaming at full rate.
        for (int i = 0; i < 16; i++) begin
            set_words(1, rand_blk());
            v_in[1] = 1'b1;
            #1 check_eq("st_ready", 128'(ordy[1]), 128'(1));
            if (i >= 2) check_eq("st_valid", 128'(ov[1]), 128'(1));
            tick();
        end
        v_in[1] = 1'b0;
        check_eq("st_tail0", 128'(ov[1]), 128'(1));
        tick();
        check_eq("st_tail1", 128'(ov[1]), 128'(1));
        tick();
        check_eq("st_end", 128'(ov[1]), 128'(0));

        // Random valid/ready on both instances; the zero vector goes first.
        for (int k = 0; k < 2; k++) begin
            set_words(k, '0);
            v_in[k] = 1'b1;
        end
        repeat (10000) begin
            #1;
            for (int k = 0; k < 2; k++) acc[k] = v_in[k] && ordy[k];
            tick();
            for (int k = 0; k < 2; k++) begin
                if (!v_in[k] || acc[k]) begin
                    v_in[k] = ($urandom_range(0, 3) != 0);
                    set_words(k, rand_blk());
                end
                rdy_dn[k] = ($urandom_range(0, 3) != 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            v_in[k]   = 1'b0;
            rdy_dn[k] = 1'b1;
        end
        repeat (6) tick();
        check_eq("rnd_s1_count", 128'(g_inst[0].n_out), 128'(g_inst[0].n_in));
        check_eq("rnd_s2_count", 128'(g_inst[1].n_out), 128'(g_inst[1].n_in));
        check_eq("rnd_s1_volume", 128'(g_inst[0].n_out >= 1000), 128'(1));
        check_eq("rnd_s2_volume", 128'(g_inst[1].n_out >= 1000), 128'(1));

        // Asynchronous reset with two entries in flight.
        rdy_dn[1] = 1'b0;
        v_in[1]   = 1'b1;
        set_words(1, rand_blk());
        tick();
        set_words(1, rand_blk());
        tick();
        v_in[1] = 1'b0;
        check_eq("ar_pre_valid", 128'(ov[1]), 128'(1));
        check_eq("ar_pre_busy", 128'(busy[1]), 128'(1));
        #2 rst = 1'b1;
        #1;
        check_eq("ar_valid", 128'(ov[1]), 128'(0));
        check_eq("ar_busy", 128'(busy[1]), 128'(0));
        check_eq("ar_words", out_blk(1), 128'(0));
        tick();
        #2 rst = 1'b0;
        rdy_dn[1] = 1'b1;
        #1 check_eq("ar_ready", 128'(ordy[1]), 128'(1));
        repeat (4) begin
            tick();
            check_eq("ar_no_stale", 128'(ov[1]), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
